// File: rtl/add_1p_pkg.sv
// add_1p shared widths.
// Split point of the two-stage carry chain.
package add_1p_pkg;

  localparam int ADD_1P_WIDTH    = 15;
  localparam int ADD_1P_WIDTH_LO = 7;
  localparam int ADD_1P_WIDTH_HI =
    ADD_1P_WIDTH - ADD_1P_WIDTH_LO;

endpackage

// File: rtl/add_1p_slice.sv
// add_1p_slice: N-bit unsigned adder
// with carry-in and carry-out.
module add_1p_slice #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] full;

  assign full = {1'b0, a}
              + {1'b0, b}
              + {{N{1'b0}}, cin};

  assign s    = full[N-1:0];
  assign cout = full[N];

endmodule

// File: rtl/add_1p.sv
// add_1p: unsigned adder, carry chain
// split across one pipeline register.
module add_1p
  import add_1p_pkg::*;
#(
  parameter int WIDTH    = ADD_1P_WIDTH,
  parameter int WIDTH_LO = ADD_1P_WIDTH_LO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] sum
);

  localparam int WIDTH_HI = WIDTH - WIDTH_LO;

  logic [WIDTH_LO-1:0] lo_sum;
  logic                lo_cout;
  logic [WIDTH_HI-1:0] hi_sum;
  logic                hi_cout_unused;

  logic [WIDTH_LO-1:0] lo_sum_r;
  logic                carry_r;
  logic [WIDTH_HI-1:0] xh_r;
  logic [WIDTH_HI-1:0] yh_r;

  add_1p_slice #(
    .N (WIDTH_LO)
  ) u_lo (
    .a    (X[WIDTH_LO-1:0]),
    .b    (Y[WIDTH_LO-1:0]),
    .cin  (1'b0),
    .s    (lo_sum),
    .cout (lo_cout)
  );

  // MSB carry is dropped: result wraps mod 2^WIDTH
  add_1p_slice #(
    .N (WIDTH_HI)
  ) u_hi (
    .a    (xh_r),
    .b    (yh_r),
    .cin  (carry_r),
    .s    (hi_sum),
    .cout (hi_cout_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_sum_r <= '0;
      carry_r  <= 1'b0;
      xh_r     <= '0;
      yh_r     <= '0;
      sum      <= '0;
    end else begin
      lo_sum_r <= lo_sum;
      carry_r  <= lo_cout;
      xh_r     <= X[WIDTH-1:WIDTH_LO];
      yh_r     <= Y[WIDTH-1:WIDTH_LO];
      sum      <= {hi_sum, lo_sum_r};
    end
  end

endmodule

// File: tb/tb_add_1p.sv
// tb_add_1p: directed vectors for add_1p.
// Outputs are sampled on the falling edge.
module tb_add_1p;

  localparam int W = 15;
  localparam int NV = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] X = '0;
  logic [W-1:0] Y = '0;
  logic [W-1:0] sum;

  int n_vec = 0;
  int n_bad = 0;

  logic [W-1:0] xv [NV] = '{
    15'd10, 15'd1001, 15'd15383, 15'd16003,
    15'd127, 15'd32767, 15'd32767};
  logic [W-1:0] yv [NV] = '{
    15'd0, 15'd1001, 15'd15402, 15'd1023,
    15'd1, 15'd1, 15'd32767};
  logic [W-1:0] ev [NV] = '{
    15'd10, 15'd2002, 15'd30785, 15'd17026,
    15'd128, 15'd0, 15'd32766};

  add_1p u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .X     (X),
    .Y     (Y),
    .sum   (sum)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [W-1:0] got,
    input logic [W-1:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  initial begin
    // reset held 3 cycles with junk operands
    X = 15'd12345;
    Y = 15'd22222;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold", sum, '0);
    end

    // release with first pair applied
    rst_n = 1'b1;
    X = xv[0];
    Y = yv[0];
    @(posedge clk);
    @(negedge clk);
    chk("rel_e1", sum, '0);
    @(posedge clk);
    @(negedge clk);
    chk("rel_e2", sum, ev[0]);

    // each pair held 5 cycles
    for (int i = 0; i < NV; i++) begin
      X = xv[i];
      Y = yv[i];
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("held%0d_e2", i), sum, ev[i]);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("held%0d_e5", i), sum, ev[i]);
    end

    // back-to-back stream, 2-edge delay
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2)
        chk($sformatf("strm%0d", i - 2),
            sum, ev[i - 2]);
      if (i < NV) begin
        X = xv[i];
        Y = yv[i];
      end
      @(posedge clk);
      @(negedge clk);
    end

    // reset in mid-stream
    X = xv[2];
    Y = yv[2];
    @(posedge clk);
    @(negedge clk);
    X = xv[3];
    Y = yv[3];
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_now", sum, '0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_hold", sum, '0);
    rst_n = 1'b1;
    X = xv[1];
    Y = yv[1];
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_e1", sum, '0);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_e2", sum, ev[1]);
    X = xv[4];
    Y = yv[4];
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_next", sum, ev[4]);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/add_1p.md
# add_1p

One-stage pipelined 15-bit unsigned adder. The carry chain is split into a low half and a high half, with one pipeline register between them, so the adder can close timing at higher clock rates than a single ripple adder. It accepts a new operand pair every cycle and delivers the modulo-2^WIDTH sum two clock edges later. It is a datapath leaf used wherever a registered wide add is needed.

## Interface
- WIDTH, 15: operand and sum width in bits.
- WIDTH_LO, 7: width of the low half, bits [WIDTH_LO-1:0]. Requirement: 1 ≤ WIDTH_LO < WIDTH. The high half is WIDTH-WIDTH_LO bits (8 by default).

- clk  input  1  rising-edge clock; the single clock domain.
- rst_n  input  1  asynchronous reset, active-low; clears every pipeline register.
- X  input  WIDTH  unsigned operand A, sampled every rising edge.
- Y  input  WIDTH  unsigned operand B, sampled every rising edge.
- sum  output  WIDTH  registered (X+Y) mod 2^WIDTH.

## Operation
- Stage 1, registered at edge n:
  - lo_sum_r = X[lo] + Y[lo], kept as WIDTH_LO bits.
  - carry_r = carry out of that low add.
  - xh_r = X[hi] and yh_r = Y[hi], passed through unchanged.
- Stage 2, registered at edge n+1:
  - sum[hi] = xh_r + yh_r + carry_r, truncated to WIDTH-WIDTH_LO bits.
  - sum[lo] = lo_sum_r.
- Overflow: the carry out of the MSB is discarded and the result wraps modulo 2^WIDTH. No carry or overflow port exists.
- All arithmetic is unsigned. Each half uses a width+1 intermediate only to extract its carry.
- No valid/enable handshake. Every edge advances the pipeline, and the output is meaningful only for inputs that were held valid at the sampling edge.
- Undriven (X) inputs propagate X to sum. No masking is performed.

## Timing
- Latency: inputs stable before edge n produce sum valid after edge n+1, a 2-edge latency.
- Throughput: one result per cycle; back-to-back operand changes each cycle are legal.
- sum is driven directly from flops, with no combinational path from X/Y to sum.
- Reset:
  - Asserting rst_n=0 at any time immediately forces lo_sum_r, carry_r, xh_r, yh_r and sum to 0.
  - While rst_n=0, sum stays 0.
  - After deassertion, the first valid sum appears 2 edges after the first sampled operands.
  - Reset mid-operation discards all in-flight additions.
- Deassertion is expected to be synchronized to clk externally.

## Structure
- Shared package add_1p_pkg:
  - ADD_1P_WIDTH = 15.
  - ADD_1P_WIDTH_LO = 7.
  - Derived ADD_1P_WIDTH_HI.
- Natural sub-module: add_1p_slice, a parameterized N-bit adder with carry-in and carry-out. It is instantiated twice: the low slice with cin=0, and the high slice fed by carry_r.
- Pipeline registers live in add_1p itself, in one always block sensitive to posedge clk and negedge rst_n.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with any X/Y -> sum=0 throughout. Release -> sum=0 until the first sampled pair emerges 2 edges later.
- Basic adds, with each pair held ≥5 cycles and sum checked 2 edges after each change:
  - X=10, Y=0 -> sum=10.
  - X=1001, Y=1001 -> sum=2002.
  - X=15383, Y=15402 -> sum=30785.
  - X=16003, Y=1023 -> sum=17026.
- Carry across the split: X=127, Y=1 (low half 0x7F+0x01) -> sum=128, confirming carry_r reaches the high half.
- Wrap-around: X=32767, Y=1 -> sum=0. X=32767, Y=32767 -> sum=32766.
- Streaming: change X/Y every cycle through the pairs above -> sum sequence matches each pair delayed exactly 2 edges, with no bubbles.
- Reset mid-stream: assert rst_n=0 between two clock edges -> sum=0 immediately. On release, the first post-reset pair appears after 2 edges and no stale result is ever output.
